// File: rtl/clk_sel_pkg.sv
// Shared definitions for the pixel-clock select sequencer and the mux wrapper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package clk_sel_pkg;

    // Sequencer states; the reset state is WAIT_LOCK so lock is confirmed before
    // the video pipeline is first released.
    typedef enum logic [2:0] {
        IDLE,
        QUIESCE,
        SWITCH,
        SETTLE,
        WAIT_LOCK,
        RELEASE
    } state_t;

    // Select codes for the 4:1 pixel-clock mux.
    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

    // Largest of four timing parameters, used to size the shared counters.
    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
// Latency: 2 clk cycles from input change to o_q.
// Backpressure: none; level signal, always sampled.
// Ports: clk/rst (sync, active-high), i_d async input, o_q synchronized output.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/clk_sel_ctrl.sv
// Sequencer driving the pixel-clock mux select: quiesce, switch, settle, wait for lock, release.
// Latency: no-op request -> done 1 cycle; switch -> PRE+1+POST+LOCK_STABLE+1 cycles with lock high.
// Backpressure: none; requests while busy park in a one-deep last-wins register.
// Ports: clk/rst (sync, active-high); req_valid/req_sel request; mmcm_locked async lock;
//        sel mux select; video_rst pipeline reset; busy (state != IDLE); done pulse; err sticky timeout.
module clk_sel_ctrl
    import clk_sel_pkg::*;
#(
    parameter int         PRE_CYCLES  = 16,
    parameter int         POST_CYCLES = 64,
    parameter int         LOCK_STABLE = 256,
    parameter int         TIMEOUT     = 1048576,
    parameter logic [1:0] DEFAULT_SEL = SEL_A
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [1:0] req_sel,
    input  logic       mmcm_locked,
    output logic [1:0] sel,
    output logic       video_rst,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int CW = $clog2(max_of4(PRE_CYCLES, POST_CYCLES, LOCK_STABLE, TIMEOUT)) + 1;
    localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_CYCLES - 1);
    localparam logic [CW-1:0] POST_LAST = CW'(POST_CYCLES - 1);
    localparam logic [CW-1:0] LS_CNT    = CW'(LOCK_STABLE);
    localparam logic [CW-1:0] TMO_CNT   = CW'(TIMEOUT);

    state_t          r_state, w_state;
    logic [CW-1:0]   r_cnt, w_cnt;      // phase count in QUIESCE/SETTLE, stable count in WAIT_LOCK
    logic [CW-1:0]   r_tmo, w_tmo;
    logic [1:0]      r_sel, w_sel;
    logic [1:0]      r_tgt, w_tgt;
    logic            r_vrst, w_vrst;
    logic            r_done, w_done;
    logic            r_err, w_err;
    logic            r_pend_vld, w_pend_vld;
    logic [1:0]      r_pend_sel, w_pend_sel;

    logic            w_lock_s;
    logic [CW-1:0]   w_cnt_inc;
    logic [CW-1:0]   w_tmo_inc;
    logic [CW-1:0]   w_stable;
    logic            w_req_vld;
    logic [1:0]      w_req_sel;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (rst),
        .i_d (mmcm_locked),
        .o_q (w_lock_s)
    );

    // Saturating increments so no counter ever wraps.
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CW'(1);
    assign w_tmo_inc = (&r_tmo) ? r_tmo : r_tmo + CW'(1);
    assign w_stable  = w_lock_s ? w_cnt_inc : '0;

    // A live request this cycle beats a parked one (last wins).
    assign w_req_vld = req_valid | r_pend_vld;
    assign w_req_sel = req_valid ? req_sel : r_pend_sel;

    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_tmo      = r_tmo;
        w_sel      = r_sel;
        w_tgt      = r_tgt;
        w_vrst     = r_vrst;
        w_done     = 1'b0;
        w_err      = r_err;
        w_pend_vld = r_pend_vld;
        w_pend_sel = r_pend_sel;

        if ((r_state != IDLE) && req_valid) begin
            w_pend_vld = 1'b1;
            w_pend_sel = req_sel;
        end

        case (r_state)
            IDLE: begin
                // After a lock timeout the pipeline stays held until a new switch succeeds.
                w_vrst = r_err;
                if (w_req_vld) begin
                    w_pend_vld = 1'b0;
                    if (w_req_sel == r_sel) begin
                        w_done = 1'b1;
                    end else begin
                        w_tgt   = w_req_sel;
                        w_err   = 1'b0;
                        w_vrst  = 1'b1;
                        w_cnt   = '0;
                        w_state = QUIESCE;
                    end
                end
            end
            QUIESCE: begin
                if (r_cnt == PRE_LAST) begin
                    // Select moves on entry to SWITCH, after the pipeline has been held PRE cycles.
                    w_sel   = r_tgt;
                    w_cnt   = '0;
                    w_state = SWITCH;
                end else begin
                    w_cnt = w_cnt_inc;
                end
            end
            SWITCH: begin
                w_cnt   = '0;
                w_state = SETTLE;
            end
            SETTLE: begin
                if (r_cnt == POST_LAST) begin
                    w_cnt   = '0;
                    w_tmo   = '0;
                    w_state = WAIT_LOCK;
                end else begin
                    w_cnt = w_cnt_inc;
                end
            end
            WAIT_LOCK: begin
                w_cnt = w_stable;
                w_tmo = w_tmo_inc;
                if (w_stable == LS_CNT) begin
                    w_state = RELEASE;
                end else if (w_tmo_inc == TMO_CNT) begin
                    // Parked request (if any) is picked up from IDLE next cycle.
                    w_err   = 1'b1;
                    w_state = IDLE;
                end
            end
            RELEASE: begin
                w_done     = 1'b1;
                w_pend_vld = 1'b0;
                if (w_req_vld && (w_req_sel != r_sel)) begin
                    // Chain straight into the next switch; pipeline stays in reset.
                    w_tgt   = w_req_sel;
                    w_cnt   = '0;
                    w_state = QUIESCE;
                end else begin
                    w_vrst  = 1'b0;
                    w_state = IDLE;
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= WAIT_LOCK;
            r_cnt      <= '0;
            r_tmo      <= '0;
            r_sel      <= DEFAULT_SEL;
            r_tgt      <= DEFAULT_SEL;
            r_vrst     <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_pend_vld <= 1'b0;
            r_pend_sel <= DEFAULT_SEL;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_tmo      <= w_tmo;
            r_sel      <= w_sel;
            r_tgt      <= w_tgt;
            r_vrst     <= w_vrst;
            r_done     <= w_done;
            r_err      <= w_err;
            r_pend_vld <= w_pend_vld;
            r_pend_sel <= w_pend_sel;
        end
    end

    assign sel       = r_sel;
    assign video_rst = r_vrst;
    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// Scoreboard bench for clk_sel_ctrl with a cycle-level reference model of lock qualification.
// Latency: n/a.
// Backpressure: n/a.
module tb_clk_sel_ctrl;

    localparam int PRE_P  = 4;
    localparam int POST_P = 8;
    localparam int LS_P   = 4;
    localparam int TMO_P  = 100;
    localparam int NLK    = 8192;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [1:0] req_sel = 2'b00;
    logic       mmcm_locked = 1'b1;
    logic [1:0] sel;
    logic       video_rst, busy, done, err;

    clk_sel_ctrl #(
        .PRE_CYCLES (PRE_P),
        .POST_CYCLES(POST_P),
        .LOCK_STABLE(LS_P),
        .TIMEOUT    (TMO_P),
        .DEFAULT_SEL(2'b00)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_sel    (req_sel),
        .mmcm_locked(mmcm_locked),
        .sel        (sel),
        .video_rst  (video_rst),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    typedef struct {
        bit         is_err;
        int         cyc;
        logic [1:0] sel;
        logic       vrst;
        logic       err;
    } exp_t;

    exp_t sb[$];
    exp_t mx;
    exp_t dropped;
    bit   lk [NLK];          // mmcm_locked value driven during each cycle
    int   cyc = 0;
    int   rst_rel = 0;       // first edge with rst low
    int   n_chk = 0;
    int   n_fail = 0;
    bit   mon_on = 1'b0;
    logic [1:0] sel_q = 2'b00;
    logic vrst_q = 1'b1;
    logic err_q = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) mmcm_locked = (cyc < NLK) ? lk[cyc] : 1'b1;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse and every err rise.
    always @(negedge clk) begin
        if (mon_on) begin
            if (sel !== sel_q)
                check("sel_change_while_held", int'(video_rst & vrst_q), 1);
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    mx = sb.pop_front();
                    check("done_kind", int'(mx.is_err), 0);
                    check("done_cycle", cyc, mx.cyc);
                    check("done_sel", int'(sel), int'(mx.sel));
                    check("done_video_rst", int'(video_rst), int'(mx.vrst));
                    check("done_err", int'(err), int'(mx.err));
                end
            end
            if (err && !err_q) begin
                if (sb.size() == 0) begin
                    check("unexpected_err", 1, 0);
                end else begin
                    mx = sb.pop_front();
                    check("err_kind", int'(mx.is_err), 1);
                    check("err_cycle", cyc, mx.cyc);
                    check("err_sel", int'(sel), int'(mx.sel));
                    check("err_video_rst", int'(video_rst), 1);
                end
            end
        end
        sel_q  = sel;
        vrst_q = video_rst;
        err_q  = err;
    end

    task automatic to_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic push(input bit ie, input int c, input logic [1:0] s, input logic v, input logic e);
        exp_t x;
        x = '{ie, c, s, v, e};
        sb.push_back(x);
    endtask

    task automatic issue(input logic [1:0] s);
        req_valid = 1'b1;
        req_sel   = s;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Lock qualification: WAIT_LOCK is entered at edge w; on each following edge the
    // synchronized lock (mmcm_locked as driven three cycles earlier, zero for two edges
    // after reset) extends or restarts the run. LS_P in a row releases (done one edge
    // later); TMO_P edges without that raises err on that edge.
    task automatic model_wait(input int w, output int ecyc, output bit is_err);
        int run, e;
        bit l;
        run = 0; is_err = 1'b0; ecyc = -1;
        for (int j = 1; j <= TMO_P; j++) begin
            e = w + j;
            l = (e >= rst_rel + 2 && e >= 3) ? lk[e-3] : 1'b0;
            run = l ? run + 1 : 0;
            if (run >= LS_P) begin
                ecyc = e + 1;
                return;
            end
            if (j == TMO_P) begin
                ecyc = e;
                is_err = 1'b1;
                return;
            end
        end
    endtask

    // mode: 0 lock high, 1 lock pattern 1,1,0,1,1,1,1 in WAIT_LOCK, 2 lock low, 3 random glitch
    task automatic do_switch(input logic [1:0] tgt, input int mode, input bit chained,
                             output int e0, output int ecyc, output bit is_err);
        int w, gs, gl;
        bit [6:0] pat;
        e0 = cyc + 1;
        w  = e0 + PRE_P + 1 + POST_P;
        pat = 7'b1111011;
        case (mode)
            1: for (int j = 1; j <= 7; j++) lk[w+j-3] = pat[j-1];
            2: for (int j = e0; j <= w + TMO_P; j++) lk[j] = 1'b0;
            3: begin
                gs = $urandom_range(1, 4);
                gl = $urandom_range(1, 3);
                for (int j = 0; j < gl; j++) lk[w+gs+j-3] = 1'b0;
            end
            default: ;
        endcase
        model_wait(w, ecyc, is_err);
        if (is_err) push(1'b1, ecyc, tgt, 1'b1, 1'b1);
        else        push(1'b0, ecyc, tgt, chained, 1'b0);
        issue(tgt);
    endtask

    task automatic do_noop(input logic [1:0] s);
        push(1'b0, cyc + 1, s, 1'b0, 1'b0);
        issue(s);
    endtask

    task automatic release_reset();
        int ec;
        bit ie;
        rst = 1'b0;
        rst_rel = cyc + 1;
        model_wait(rst_rel - 1, ec, ie);
        push(ie, ec, 2'b00, ie, ie);
        to_cyc(ec + 1);
        check("post_reset_busy", int'(busy), 0);
        check("post_reset_video_rst", int'(video_rst), 0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_sel"}, int'(sel), 0);
        check({tag, "_video_rst"}, int'(video_rst), 1);
        check({tag, "_busy"}, int'(busy), 1);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_err"}, int'(err), 0);
    endtask

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, ec, ec2, w2;
        bit ie;
        logic [1:0] cur, tgt;

        for (int i = 0; i < NLK; i++) lk[i] = 1'b1;

        // 1: reset with lock high
        repeat (3) @(negedge clk);
        mon_on = 1'b1;
        check_reset_state("reset");
        release_reset();
        cur = 2'b00;

        // 3: no-op request
        do_noop(2'b00);
        repeat (3) @(negedge clk);

        // 2: switch 00 -> 10, exact edge timing
        do_switch(2'b10, 0, 1'b0, e0, ec, ie);
        check("vrst_rises_next_cycle", int'(video_rst), 1);
        check("busy_during_switch", int'(busy), 1);
        to_cyc(e0 + PRE_P - 1);
        check("sel_before_switch", int'(sel), 0);
        to_cyc(e0 + PRE_P);
        check("sel_after_switch", int'(sel), 2);
        to_cyc(ec + 1);
        cur = 2'b10;

        // 4: lock toggles during WAIT_LOCK
        tgt = 2'($urandom_range(0, 2));
        if (tgt == cur) tgt = 2'b11;
        do_switch(tgt, 1, 1'b0, e0, ec, ie);
        to_cyc(ec + 1);
        cur = tgt;

        // 5: lock timeout, then recovery to 01
        tgt = (cur != 2'b11) ? 2'b11 : 2'b00;
        do_switch(tgt, 2, 1'b0, e0, ec, ie);
        to_cyc(ec + 3);
        check("timeout_video_rst_held", int'(video_rst), 1);
        check("timeout_busy", int'(busy), 0);
        check("timeout_err_sticky", int'(err), 1);
        do_switch(2'b01, 0, 1'b0, e0, ec, ie);
        check("err_cleared_on_accept", int'(err), 0);
        to_cyc(ec + 1);
        cur = 2'b01;

        // 6a: two requests during QUIESCE of 01 -> 10; last (11) wins
        do_switch(2'b10, 0, 1'b1, e0, ec, ie);
        issue(2'b01);
        issue(2'b11);
        w2 = ec + PRE_P + 1 + POST_P;
        model_wait(w2, ec2, ie);
        push(ie, ec2, 2'b11, ie, ie);
        to_cyc(ec2 + 1);
        check("pending_last_wins", int'(sel), 3);
        cur = 2'b11;

        // 6b: rst during SETTLE with a parked request
        do_switch(2'b10, 0, 1'b0, e0, ec, ie);
        dropped = sb.pop_back();
        issue(2'b01);
        to_cyc(e0 + PRE_P + 3);
        check("settle_sel_switched", int'(sel), 2);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_state("mid_reset");
        release_reset();
        repeat (30) @(negedge clk);
        check("pending_lost_sel", int'(sel), 0);
        check("pending_lost_busy", int'(busy), 0);
        cur = 2'b00;

        // randomized requests, some with lock glitches in WAIT_LOCK
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            tgt = 2'($urandom_range(0, 3));
            if (tgt == cur) begin
                do_noop(tgt);
                repeat (2) @(negedge clk);
            end else begin
                do_switch(tgt, ($urandom_range(0, 1) == 1) ? 3 : 0, 1'b0, e0, ec, ie);
                to_cyc(ec + 1);
                cur = tgt;
            end
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        check("final_sel", int'(sel), int'(cur));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
